// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : prog_clk_div
//  Description : Fully synchronous programmable clock divider. It produces a
//                divided square wave (clk_out) and a one-cycle enable strobe
//                (tick) for any divisor 2..2^DIV_W-1. The divisor can be
//                reprogrammed at run time and only takes effect on a period
//                boundary, so the output never glitches.
//  Options     : PROG_CLK_DIV_ODD_DUTY50_EN - adds a falling-edge retiming
//                register so that odd divisors give an exact 50% duty cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_clk_div #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_err,
    output logic             pending
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic [DIV_W-1:0] n_div;      // active divisor N
    logic [DIV_W-1:0] p_div;      // pending divisor P
    logic [DIV_W-1:0] ph;         // phase counter, 0..N-1
    logic             clk_q;      // posedge-registered divided clock

    logic             wrap;       // this edge closes the current period
    logic [DIV_W:0]   high_cnt;   // H = (N+1)>>1, one bit wider so N=max is safe
    logic [DIV_W:0]   ph_inc;     // ph+1, widened for the H comparison
    logic             div_ok;     // requested divisor is legal

    assign wrap     = en && (ph == (n_div - ONE));
    assign high_cnt = ({1'b0, n_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    assign ph_inc   = {1'b0, ph} + {{DIV_W{1'b0}}, 1'b1};
    assign div_ok   = (div_val >= TWO);

    // Phase counter, divisor hand-over and all registered strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_div   <= RST_DIV;
            p_div   <= RST_DIV;
            ph      <= RST_DIV - ONE;
            pending <= 1'b0;
            clk_q   <= 1'b0;
            tick    <= 1'b0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_ack <= 1'b0;
            div_err <= 1'b0;

            if (en) begin
                if (wrap) begin
                    // Start of a new period; ph=0 is always inside the high time.
                    ph    <= '0;
                    clk_q <= 1'b1;
                    tick  <= 1'b1;
                    if (pending) begin
                        n_div   <= p_div;
                        pending <= 1'b0;
                        div_ack <= 1'b1;
                    end
                end else begin
                    ph    <= ph_inc[DIV_W-1:0];
                    clk_q <= (ph_inc < high_cnt);
                end
            end

            // A load on the wrap edge lands after the hand-over above: the
            // old P was consumed with its pre-edge value, the new one waits.
            if (div_ld) begin
                if (div_ok) begin
                    p_div   <= div_val;
                    pending <= 1'b1;
                end else begin
                    div_err <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
    logic qn;

    // Half-cycle delayed copy of clk_q; ANDing trims half a cycle off the
    // high time, which turns (N+1)/2 into exactly N/2 for odd N.
    always_ff @(negedge clk) begin
        if (!rst) begin
            qn <= 1'b0;
        end else begin
            qn <= clk_q;
        end
    end

    assign clk_out = n_div[0] ? (clk_q & qn) : clk_q;
`else
    assign clk_out = clk_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_clk_div
//  Description : Directed self-checking bench for prog_clk_div (DIV_W=8,
//                DEFAULT_DIV=16). Outputs are sampled 1 ns after each rising
//                edge; inputs are changed at that same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_ld;
    logic [7:0] div_val;
    logic       clk_out;
    logic       tick;
    logic       div_ack;
    logic       div_err;
    logic       pending;

    int n_checks;
    int n_fail;

    prog_clk_div #(
        .DIV_W       (8),
        .DEFAULT_DIV (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_ld  (div_ld),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .div_ack (div_ack),
        .div_err (div_err),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Expected high samples for odd divisors depend on the duty option.
`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
    localparam int HIGH5 = 2;
    localparam int HIGH9 = 4;
`else
    localparam int HIGH5 = 3;
    localparam int HIGH9 = 5;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Advance until the next tick; reports cycles taken (-1 on timeout),
    // clk_out high samples seen before the tick, and div_ack pulses before it.
    task automatic measure(output int per, output int highs, output int acks);
        int c;
        per   = -1;
        highs = int'(clk_out);
        acks  = 0;
        c     = 0;
        while (c < 600) begin
            step();
            c++;
            if (tick) begin
                per = c;
                break;
            end
            highs += int'(clk_out);
            acks  += int'(div_ack);
        end
    endtask

    task automatic test_reset();
        int per, highs, acks;
        rst = 1'b0; en = 1'b0;
        step_n(2);
        n_checks++;
        if ({clk_out, tick, div_ack, div_err, pending} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {clk_out, tick, div_ack, div_err, pending});
        end
        rst = 1'b1; en = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b1 || clk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: tick=%b clk_out=%b expected 1 1", tick, clk_out);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 16 || highs !== 8) begin
            n_fail++;
            $display("FAIL default_period: period=%0d high=%0d expected 16 8", per, highs);
        end
    endtask

    task automatic test_invalid_load();
        int per, highs, acks;
        step_n(3);
        div_ld = 1'b1; div_val = 8'd0;
        step();
        n_checks++;
        if (div_err !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL err_val0: div_err=%b pending=%b expected 1 0", div_err, pending);
        end
        div_val = 8'd1;
        step();
        n_checks++;
        if (div_err !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL err_val1: div_err=%b pending=%b expected 1 0", div_err, pending);
        end
        div_ld = 1'b0;
        step();
        n_checks++;
        if (div_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: div_err=%b expected 0", div_err);
        end
        measure(per, highs, acks);
        n_checks++;
        if (div_ack !== 1'b0 || acks !== 0) begin
            n_fail++;
            $display("FAIL err_no_ack: ack=%b acks=%0d expected 0 0", div_ack, acks);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 16 || highs !== 8) begin
            n_fail++;
            $display("FAIL err_keep_div: period=%0d high=%0d expected 16 8", per, highs);
        end
    endtask

    task automatic test_divisor_change();
        int per, highs, acks;
        step_n(3);
        div_ld = 1'b1; div_val = 8'd5;
        step();
        div_ld = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || div_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_pending: pending=%b ack=%b expected 1 0", pending, div_ack);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 12 || div_ack !== 1'b1 || pending !== 1'b0 || acks !== 0) begin
            n_fail++;
            $display("FAIL chg_apply: period=%0d ack=%b pending=%b early_acks=%0d expected 12 1 0 0",
                     per, div_ack, pending, acks);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 5 || highs !== HIGH5 || div_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_period5: period=%0d high=%0d ack=%b expected 5 %0d 0",
                     per, highs, div_ack, HIGH5);
        end
    endtask

    task automatic test_enable_gating();
        int per, highs, acks, ticks, changes;
        logic held;
        div_ld = 1'b1; div_val = 8'd6;
        step();
        div_ld = 1'b0;
        measure(per, highs, acks);
        n_checks++;
        if (div_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_load6: ack=%b expected 1", div_ack);
        end
        step_n(3);
        held = clk_out;
        n_checks++;
        if (held !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_ph3: clk_out=%b expected 0", held);
        end
        en = 1'b0;
        ticks = 0; changes = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            ticks   += int'(tick);
            changes += int'(clk_out !== held);
        end
        n_checks++;
        if (ticks !== 0 || changes !== 0) begin
            n_fail++;
            $display("FAIL gate_hold: ticks=%0d clk_changes=%0d expected 0 0", ticks, changes);
        end
        en = 1'b1;
        measure(per, highs, acks);
        n_checks++;
        if (per !== 3) begin
            n_fail++;
            $display("FAIL gate_resume: cycles_to_tick=%0d expected 3", per);
        end
    endtask

    task automatic test_simultaneous();
        int per, highs, acks;
        div_ld = 1'b1; div_val = 8'd4;
        step();
        div_ld = 1'b0;
        step_n(4);
        div_ld = 1'b1; div_val = 8'd9;
        step();
        div_ld = 1'b0;
        n_checks++;
        if (tick !== 1'b1 || div_ack !== 1'b1 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_wrap: tick=%b ack=%b pending=%b expected 1 1 1",
                     tick, div_ack, pending);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 4 || div_ack !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_period4: period=%0d ack=%b pending=%b expected 4 1 0",
                     per, div_ack, pending);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 9 || highs !== HIGH9) begin
            n_fail++;
            $display("FAIL sim_period9: period=%0d high=%0d expected 9 %0d", per, highs, HIGH9);
        end
    endtask

    task automatic test_back_to_back();
        int per, highs, acks;
        div_ld = 1'b1; div_val = 8'd7;
        step();
        div_val = 8'd3;
        step();
        div_ld = 1'b0;
        measure(per, highs, acks);
        n_checks++;
        if (div_ack !== 1'b1 || acks !== 0) begin
            n_fail++;
            $display("FAIL b2b_ack: ack=%b early_acks=%0d expected 1 0", div_ack, acks);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 3 || div_ack !== 1'b0 || acks !== 0) begin
            n_fail++;
            $display("FAIL b2b_period3: period=%0d ack=%b acks=%0d expected 3 0 0",
                     per, div_ack, acks);
        end
    endtask

    task automatic test_reset_mid();
        int per, highs, acks;
        div_ld = 1'b1; div_val = 8'd10;
        step();
        div_ld = 1'b0;
        step();
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pending: pending=%b expected 1", pending);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({clk_out, tick, div_ack, div_err, pending} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %b expected 00000",
                     {clk_out, tick, div_ack, div_err, pending});
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b1 || div_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_first_tick: tick=%b ack=%b expected 1 0", tick, div_ack);
        end
        measure(per, highs, acks);
        n_checks++;
        if (per !== 16 || highs !== 8 || div_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_period: period=%0d high=%0d ack=%b expected 16 8 0",
                     per, highs, div_ack);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; en = 1'b0; div_ld = 1'b0; div_val = 8'd0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_invalid_load();
        test_divisor_change();
        test_enable_gating();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
